addsub_acc_sequencer: RTL and testbench
=======================================

Name: addsub_acc_sequencer

Overview:
- Downstream consumer stage for the 8-bit adder/subtractor datapath.
- Accepts a counted burst of operand beats, each tagged add or subtract.
- Folds each beat into a running accumulator using the same add/subtract arithmetic: sum = a + (b XOR {WIDTH{k}}) + k.
- Presents the final result with carry and sticky signed-overflow flags over a valid/ready handshake.

Parameters:
- WIDTH, 8: operand and accumulator width in bits.
- LEN_W, 4: width of the burst-length field; maximum burst is 2^LEN_W - 1 beats.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a burst; sampled only in IDLE.
- len  input  LEN_W  number of beats in the burst; sampled with start.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  stage can accept a beat.
- in_data  input  WIDTH  operand b for this beat.
- in_k  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_acc  output  WIDTH  final accumulator value.
- out_cout  output  1  carry-out of the last accepted beat; for subtract, 1 = no borrow.
- out_ovf  output  1  sticky two's-complement overflow over the whole burst.
- busy  output  1  high in ACC or DONE.

Behaviour:
- Clock and reset: single clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - state = IDLE; acc = 0; count = 0.
  - cout and ovf registers = 0.
  - in_ready = 0, out_valid = 0, busy = 0.
  - out_acc = 0, out_cout = 0, out_ovf = 0.
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - in_ready = 0, out_valid = 0.
  - start = 1 with len != 0: clear acc, cout and ovf; load count = len; go to ACC next cycle.
  - start = 1 with len = 0: clear acc, cout and ovf; go directly to DONE, so the result is acc = 0, flags 0.
- ACC:
  - in_ready = 1 combinationally in this state.
  - A transfer occurs when in_valid and in_ready are both high. On a transfer:
    - acc <= acc + (in_data XOR {WIDTH{in_k}}) + in_k, truncated to WIDTH bits.
    - cout <= carry out of bit WIDTH-1.
    - ovf <= ovf | (carry into MSB XOR carry out of MSB).
    - count <= count - 1.
  - Transfer with count == 1: go to DONE.
  - in_valid low: hold all state, no timeout.
- DONE:
  - out_valid = 1; out_acc, out_cout, out_ovf held stable.
  - out_ready = 1: return to IDLE next cycle. Outputs keep their last values in IDLE, but out_valid drops.
  - out_ready low: hold indefinitely.
- Latency:
  - A beat accepted at edge N is reflected in acc after edge N.
  - out_valid rises in the cycle after the edge accepting the last beat.
  - Minimum burst of L beats takes L+1 cycles from start to out_valid.
- start is ignored outside IDLE. A start coinciding with the DONE handshake is also ignored.
- Outputs are registered, except in_ready, out_valid and busy, which decode directly from state.
- Reset asserted mid-burst: immediate return to reset values; partial results are discarded.
- Arithmetic wraps modulo 2^WIDTH. Overflow is reported only via out_ovf; there is no saturation.

Test Plan:
- Add with wrap and overflow: start, len=2; beats (0x80,k=0), (0xC8,k=0) -> out_acc=0x48, out_cout=1, out_ovf=1; out_valid 3 cycles after start.
- Subtract from zero: start, len=1; beat (0x18,k=1) -> out_acc=0xE8, out_cout=0 (borrow), out_ovf=0.
- Mixed burst with in_valid gaps: start, len=3; beats (0x7C,0), (0x18,1), (0x9D,0) with 2 idle cycles between beats -> out_acc=0x01, out_cout=1, out_ovf=0; acc unchanged during gaps.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1 and outputs stable; a start pulse during DONE is ignored; out_ready=1 -> IDLE, in_ready stays 0.
- Zero length: start, len=0 -> out_valid next cycle with out_acc=0x00, out_cout=0, out_ovf=0; in_ready never asserts.
- Reset mid-burst: len=3, accept one beat 0x55, assert rst_n=0 asynchronously between edges -> all outputs 0 immediately; after release, a fresh burst (0x01,0), len=1 gives out_acc=0x01.

Source files
------------

// File: rtl/addsub_acc_sequencer.sv
// ---------------------------------------------------------------------------
// addsub_acc_sequencer
//
// Consumer stage for the WIDTH-bit adder/subtractor datapath. A burst of
// operand beats is requested with start/len, each beat is folded into a
// running accumulator as acc + (b ^ {WIDTH{k}}) + k, and the final value is
// offered downstream together with the carry-out of the last beat and a
// sticky two's-complement overflow flag.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a burst (honoured only in IDLE)
//   len        in   LEN_W  beats in the burst, sampled with start
//   in_valid   in   operand beat valid
//   in_ready   out  stage can accept a beat (decoded from state)
//   in_data    in   WIDTH  operand b
//   in_k       in   0 = add, 1 = subtract
//   out_valid  out  result available (decoded from state)
//   out_ready  in   downstream accepts the result
//   out_acc    out  WIDTH  final accumulator (registered)
//   out_cout   out  carry-out of last beat; for subtract 1 = no borrow
//   out_ovf    out  sticky signed overflow over the burst (registered)
//   busy       out  high in ACC or DONE (decoded from state)
// ---------------------------------------------------------------------------
module addsub_acc_sequencer #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_k,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_acc,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] LastBeat = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_acc;
    logic             r_cout;
    logic             r_ovf;
    logic [LEN_W-1:0] r_count;

    // Control strobes from the FSM into the datapath.
    logic             w_clear;
    logic             w_xfer;

    // -----------------------------------------------------------------------
    // Add/subtract datapath. Subtraction is a + ~b + 1, so the operand is
    // inverted with k and k also serves as the carry-in.
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_sum;
    logic             w_c_msb_in;
    logic             w_c_msb_out;

    assign w_b   = in_data ^ {WIDTH{in_k}};
    assign w_sum = {1'b0, r_acc} + {1'b0, w_b} + {{WIDTH{1'b0}}, in_k};

    // The carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ cin.
    assign w_c_msb_in  = w_sum[WIDTH-1] ^ r_acc[WIDTH-1] ^ w_b[WIDTH-1];
    assign w_c_msb_out = w_sum[WIDTH];

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    // NOTE: sequential state always uses non-blocking (<=) so every flop
    // samples the pre-edge values of the others regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state and state-decoded outputs
    // -----------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first; a path that leaves
    // one unassigned would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        w_clear     = 1'b0;
        w_xfer      = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_clear     = 1'b1;
                    // A zero-length burst skips ACC and reports the cleared
                    // accumulator straight away.
                    w_state_nxt = (len != '0) ? S_ACC : S_DONE;
                end
            end

            S_ACC: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    w_xfer = 1'b1;
                    if (r_count == LastBeat) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end

            S_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                // start is not looked at here, so a start coinciding with the
                // result handshake is dropped.
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Accumulator, flags and beat counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_count <= '0;
        end else if (w_clear) begin
            r_acc   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_count <= len;
        end else if (w_xfer) begin
            r_acc   <= w_sum[WIDTH-1:0];
            r_cout  <= w_c_msb_out;
            // Overflow is sticky for the whole burst: once any beat overflows,
            // the final result is flagged even if later beats wrap back.
            r_ovf   <= r_ovf | (w_c_msb_in ^ w_c_msb_out);
            r_count <= r_count - LastBeat;
        end
    end

    // Results come straight from the registers; they stay put through DONE
    // and into IDLE until the next start clears them.
    assign out_acc  = r_acc;
    assign out_cout = r_cout;
    assign out_ovf  = r_ovf;

endmodule

// File: tb/tb_addsub_acc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_addsub_acc_sequencer
//
// Directed bench for addsub_acc_sequencer. A table of bursts with
// hand-computed results is replayed in a loop; the in_valid gap, DONE
// backpressure, ignored start and mid-burst reset cases are written out
// by hand. Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_addsub_acc_sequencer;

    localparam int WIDTH = 8;
    localparam int LEN_W = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_k;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_acc;
    logic             out_cout;
    logic             out_ovf;
    logic             busy;

    addsub_acc_sequencer #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_k      (in_k),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One burst: beat operands/ops and the expected final result.
    typedef struct packed {
        logic [LEN_W-1:0]        len;
        logic [15:0][WIDTH-1:0]  d;
        logic [15:0]             k;
        logic [WIDTH-1:0]        acc;
        logic                    cout;
        logic                    ovf;
    } vec_t;

    localparam int NumVec = 6;
    vec_t vecs [NumVec];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [LEN_W-1:0] l, input logic [WIDTH-1:0] a,
                                input logic c, input logic o);
        vec_t v;
        v      = '0;
        v.len  = l;
        v.acc  = a;
        v.cout = c;
        v.ovf  = o;
        return v;
    endfunction

    // Called on a falling edge; returns on the next falling edge with start low.
    task automatic do_start(input logic [LEN_W-1:0] l);
        start = 1'b1;
        len   = l;
        @(negedge clk);
        start = 1'b0;
        len   = '0;
    endtask

    // Presents one beat for exactly one rising edge.
    task automatic send_beat(input string tag, input logic [WIDTH-1:0] d, input logic k);
        in_valid = 1'b1;
        in_data  = d;
        in_k     = k;
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // out_valid is expected immediately; the bound keeps a broken DUT from hanging.
    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".latency"}, 32'(n), 32'd0);
    endtask

    task automatic check_result(input string tag, input logic [WIDTH-1:0] a,
                                input logic c, input logic o);
        check({tag, ".out_acc"},  32'(out_acc),  32'(a));
        check({tag, ".out_cout"}, 32'(out_cout), 32'(c));
        check({tag, ".out_ovf"},  32'(out_ovf),  32'(o));
        check({tag, ".busy"},     32'(busy),     32'd1);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd0);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".idle_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".idle_busy"},  32'(busy),      32'd0);
    endtask

    initial begin
        // ------------------------------------------------------------------
        // Vector table (values worked out by hand)
        // ------------------------------------------------------------------
        // 0x80 + 0xC8 = 0x148: wraps to 0x48, carry 1, neg+neg -> pos overflow
        vecs[0] = mk(4'd2, 8'h48, 1'b1, 1'b1);
        vecs[0].d[0] = 8'h80;  vecs[0].d[1] = 8'hC8;
        // zero length right after an overflowing burst: flags must be cleared
        vecs[1] = mk(4'd0, 8'h00, 1'b0, 1'b0);
        // 0 - 0x18 = 0xE8 with borrow (cout 0), no overflow
        vecs[2] = mk(4'd1, 8'hE8, 1'b0, 1'b0);
        vecs[2].d[0] = 8'h18;  vecs[2].k[0] = 1'b1;
        // 7F, +01 -> 80 (ovf), -01 -> 7F (ovf again), -05 -> 7A; ovf sticky
        vecs[3] = mk(4'd4, 8'h7A, 1'b1, 1'b1);
        vecs[3].d[0] = 8'h7F;
        vecs[3].d[1] = 8'h01;
        vecs[3].d[2] = 8'h01;  vecs[3].k[2] = 1'b1;
        vecs[3].d[3] = 8'h05;  vecs[3].k[3] = 1'b1;
        // FF, +01 -> 00 carry (-1+1 no ovf), -00 -> 00 carry 1 (no borrow)
        vecs[4] = mk(4'd3, 8'h00, 1'b1, 1'b0);
        vecs[4].d[0] = 8'hFF;
        vecs[4].d[1] = 8'h01;
        vecs[4].d[2] = 8'h00;  vecs[4].k[2] = 1'b1;
        // maximum burst: 15 x 0x11 = 0xFF, crosses 0x77 -> 0x88 (ovf)
        vecs[5] = mk(4'd15, 8'hFF, 1'b0, 1'b1);
        for (int j = 0; j < 15; j++) vecs[5].d[j] = 8'h11;

        // ------------------------------------------------------------------
        // Reset values
        // ------------------------------------------------------------------
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_k      = 1'b0;
        out_ready = 1'b0;
        #3;
        check("rst.out_acc",   32'(out_acc),   32'd0);
        check("rst.out_cout",  32'(out_cout),  32'd0);
        check("rst.out_ovf",   32'(out_ovf),   32'd0);
        check("rst.in_ready",  32'(in_ready),  32'd0);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.busy",      32'(busy),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle.in_ready", 32'(in_ready), 32'd0);

        // ------------------------------------------------------------------
        // Table-driven bursts, back-to-back beats
        // ------------------------------------------------------------------
        for (int i = 0; i < NumVec; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            do_start(vecs[i].len);
            for (int j = 0; j < int'(vecs[i].len); j++) begin
                send_beat(tag, vecs[i].d[j], vecs[i].k[j]);
            end
            wait_valid(tag);
            check_result(tag, vecs[i].acc, vecs[i].cout, vecs[i].ovf);
            handshake(tag);
        end

        // ------------------------------------------------------------------
        // Mixed burst with two idle cycles between beats
        // 7C -> 7C; -18 -> 64; +9D -> 101 -> 01, carry 1, no overflow
        // ------------------------------------------------------------------
        do_start(4'd3);
        send_beat("gap", 8'h7C, 1'b0);
        repeat (2) begin
            @(negedge clk);
            check("gap.hold1", 32'(out_acc), 32'h7C);
        end
        send_beat("gap", 8'h18, 1'b1);
        repeat (2) begin
            @(negedge clk);
            check("gap.hold2", 32'(out_acc), 32'h64);
        end
        send_beat("gap", 8'h9D, 1'b0);
        wait_valid("gap");
        check_result("gap", 8'h01, 1'b1, 1'b0);

        // ------------------------------------------------------------------
        // Backpressure in DONE, with a start pulse that must be ignored
        // ------------------------------------------------------------------
        for (int c = 0; c < 5; c++) begin
            start = (c == 2);
            len   = (c == 2) ? 4'd1 : 4'd0;
            @(negedge clk);
            check("bp.out_valid", 32'(out_valid), 32'd1);
            check("bp.out_acc",   32'(out_acc),   32'h01);
            check("bp.out_cout",  32'(out_cout),  32'd1);
        end
        // start coinciding with the result handshake is dropped as well
        start     = 1'b1;
        len       = 4'd2;
        out_ready = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        len       = '0;
        out_ready = 1'b0;
        check("bp.idle_valid", 32'(out_valid), 32'd0);
        check("bp.idle_ready", 32'(in_ready),  32'd0);
        check("bp.idle_acc",   32'(out_acc),   32'h01);
        @(negedge clk);
        check("bp.no_start_ready", 32'(in_ready), 32'd0);
        check("bp.no_start_busy",  32'(busy),     32'd0);

        // ------------------------------------------------------------------
        // Asynchronous reset in the middle of a burst
        // ------------------------------------------------------------------
        do_start(4'd3);
        send_beat("mid", 8'h55, 1'b0);
        check("mid.partial", 32'(out_acc), 32'h55);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid.rst_acc",   32'(out_acc),   32'd0);
        check("mid.rst_busy",  32'(busy),      32'd0);
        check("mid.rst_ready", 32'(in_ready),  32'd0);
        check("mid.rst_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start(4'd1);
        send_beat("fresh", 8'h01, 1'b0);
        wait_valid("fresh");
        check_result("fresh", 8'h01, 1'b0, 1'b0);
        handshake("fresh");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
